cache_2way_wb: RTL and testbench
================================

// Module: cache_2way_wb
// PURPOSE
//  Parametrised 2-way set-associative write-back, write-allocate cache between CPU and line-wide RAM.
//  Successor to the direct-mapped cache: configurable geometry, per-set LRU, explicit cpu_ready/hit, split data buses.
//  Sits between the CPU load/store port and the RAM controller; one request outstanding at a time.
// PARAMETERS
//  ADDR_W  24  byte/word address width (one word per address)
//  DATA_W  8   CPU word width
//  WORDS   4   words per line, power of 2 >= 2; LINE_W = WORDS*DATA_W
//  SETS    16  number of sets, power of 2 >= 2
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  reset      in   1        synchronous, active-high
//  cpu_addr   in   ADDR_W   request address
//  cpu_wdata  in   DATA_W   write data
//  cpu_rd     in   1        read request, held until cpu_ready
//  cpu_wr     in   1        write request, held until cpu_ready
//  cpu_rdata  out  DATA_W   read data, valid while cpu_ready=1
//  cpu_ready  out  1        1-cycle completion pulse
//  hit        out  1        with cpu_ready: 1 = no RAM access needed
//  mem_addr   out  ADDR_W   line address, offset bits forced 0
//  mem_wdata  out  LINE_W   write-back line
//  mem_rdata  in   LINE_W   fetched line, sampled when mem_cmplt=1 in FETCH
//  mem_rd     out  1        fetch strobe, held until mem_cmplt
//  mem_wr     out  1        write-back strobe, held until mem_cmplt
//  mem_cmplt  in   1        RAM completion
// BEHAVIOUR
//  Reset: one clk with reset=1 is sufficient; all valid/dirty/LRU bits cleared; all outputs 0; FSM -> IDLE.
//  Address split: off=[log2(WORDS)-1:0], idx=next log2(SETS) bits, tag=rest.
//  Word i of a line sits at bits [i*DATA_W +: DATA_W].
//  FSM states IDLE, LOOKUP, WB, FETCH, FILL.
//   IDLE: cpu_rd|cpu_wr -> register addr/wdata/op -> LOOKUP.
//   LOOKUP hit: write word (set dirty) or read word; cpu_ready=1, hit=1; LRU := other way; -> IDLE.
//    Hit latency: cpu_ready 2 cycles after request first sampled.
//   LOOKUP miss: victim = first invalid way (way0 before way1), else LRU way.
//    Victim valid&dirty -> WB; otherwise -> FETCH.
//   WB: mem_wr=1, mem_addr={victim tag,idx,0}, mem_wdata=victim line; on mem_cmplt -> FETCH.
//   FETCH: mem_rd=1, mem_addr={tag,idx,0}; on mem_cmplt capture mem_rdata -> FILL.
//   FILL: write line, valid=1, dirty=0, new tag -> LOOKUP (hits); final cpu_ready has hit=0.
//  mem_rd and mem_wr never high together; each strobe high >=1 cycle; mem_addr/mem_wdata stable while high.
//  mem_cmplt is ignored outside WB/FETCH.
//  cpu_rd & cpu_wr both high: write wins; cpu_rdata = newly written word.
//  cpu_ready is never asserted without a sampled request.
//  Request inputs are ignored outside IDLE; cpu_ready requires deassert-or-new request in the next cycle.
//  Reset mid-miss: FSM -> IDLE; strobes drop in the next cycle; dirty data is discarded; no cpu_ready.
//  cpu_rdata holds its last value after cpu_ready deasserts; it is 0 only after reset.
// TESTING (defaults; line idx 0 = addr 0x000000..3)
//  1 Reset, read 0x000003, mem_rdata=32'hA1B2C3D4 -> mem_rd, mem_addr=0x000000, no mem_wr;
//    cpu_rdata=8'hA1, hit=0.
//  2 Write 8'h56 to 0x000003 -> cpu_ready 2 cycles later, hit=1, no mem strobe;
//    read back returns 8'h56.
//  3 Read 0x010000, mem_rdata=32'h66666666 -> fills way1, no mem_wr, rdata 8'h66;
//    then read 0x000003 -> hit, 8'h56.
//  4 Read 0x020000 -> evicts clean LRU 0x010000, no mem_wr.
//    Read 0x030000 -> mem_wr, mem_addr=0x000000, mem_wdata=32'h56B2C3D4, then mem_rd at 0x030000.
//  5 Write 8'h55 to 0x020007 (idx1 miss), mem_rdata=32'h00BCBCBC -> fetch;
//    line becomes 32'h55BCBCBC dirty; later eviction writes 32'h55BCBCBC.
//  6 Hold mem_cmplt low 10 cycles in FETCH -> mem_rd and mem_addr stable, cpu_ready=0.
//    Assert reset mid-FETCH -> mem_rd=0 next cycle; re-read 0x000003 misses.

Source files
------------

// File: rtl/cache_2way_wb.sv
// cache_2way_wb
//   Two-way set-associative, write-back, write-allocate cache between a CPU
//   load/store port and a line-wide RAM controller. Only one request is
//   outstanding at a time. Each set has one LRU bit that names the way to
//   evict next.
//
// Ports
//   clk, reset      rising-edge clock; synchronous active-high reset
//   cpu_addr        request word address: tag | idx | off
//   cpu_wdata       store data
//   cpu_rd, cpu_wr  request strobes, held until cpu_ready (write wins if both)
//   cpu_rdata       load data (or the stored word); holds until next completion
//   cpu_ready       one-cycle completion pulse
//   hit             qualifies cpu_ready: 1 = served without RAM traffic
//   mem_addr        line address with the offset bits forced to 0
//   mem_wdata       victim line during write-back
//   mem_rdata       fetched line, captured on mem_cmplt in FETCH
//   mem_rd, mem_wr  fetch / write-back strobes, held until mem_cmplt
//   mem_cmplt       RAM completion
//
// state  | meaning
// IDLE   | wait for a request; register address, data and op
// LOOKUP | tag compare; on hit complete the access, on miss choose a victim
// WB     | write the dirty victim line back to RAM
// FETCH  | read the requested line from RAM
// FILL   | install the fetched line (clean), then re-run LOOKUP
module cache_2way_wb #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int SETS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    hit,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORDS*DATA_W-1:0] mem_wdata,
  input  logic [WORDS*DATA_W-1:0] mem_rdata,
  output logic                    mem_rd,
  output logic                    mem_wr,
  input  logic                    mem_cmplt
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = WORDS * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FETCH,
    S_FILL
  } state_t;

  state_t state, state_nxt;

  logic [LINE_W-1:0] data_arr [2][SETS];
  logic [TAG_W-1:0]  tag_arr  [2][SETS];
  logic [1:0]        valid_q  [SETS];
  logic [1:0]        dirty_q  [SETS];
  logic [SETS-1:0]   lru_q;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_wr;
  logic              missed_q;   // request went through a miss; final hit=0
  logic              victim_q;
  logic [LINE_W-1:0] fill_line;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [1:0]        way_hit;
  logic              lookup_hit;
  logic              hit_way;
  logic              victim_way;
  logic              victim_dirty;
  logic [LINE_W-1:0] hit_line;
  logic [DATA_W-1:0] rd_word;
  logic              accept;

  assign req_off = req_addr[OFF_W-1:0];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];

  assign way_hit[0] = valid_q[req_idx][0] && (tag_arr[0][req_idx] == req_tag);
  assign way_hit[1] = valid_q[req_idx][1] && (tag_arr[1][req_idx] == req_tag);
  assign lookup_hit = |way_hit;
  assign hit_way    = way_hit[1];

  // Fill empty ways first (way0 before way1); only a full set uses LRU.
  assign victim_way   = !valid_q[req_idx][0] ? 1'b0 :
                        !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];
  assign victim_dirty = valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way];

  assign hit_line = data_arr[hit_way][req_idx];
  assign rd_word  = hit_line[int'(req_off)*DATA_W +: DATA_W];

  // A request still held during the cpu_ready cycle is the one just served.
  assign accept = (cpu_rd || cpu_wr) && !cpu_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (lookup_hit)        state_nxt = S_IDLE;
        else if (victim_dirty) state_nxt = S_WB;
        else                   state_nxt = S_FETCH;
      end
      S_WB: begin
        mem_wr    = 1'b1;
        mem_addr  = {tag_arr[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
        mem_wdata = data_arr[victim_q][req_idx];
        if (mem_cmplt) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_cmplt) state_nxt = S_FILL;
      end
      S_FILL: begin
        state_nxt = S_LOOKUP;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_ready <= 1'b0;
      hit       <= 1'b0;
      cpu_rdata <= '0;
      lru_q     <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wr    <= 1'b0;
      missed_q  <= 1'b0;
      victim_q  <= 1'b0;
      fill_line <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      cpu_ready <= 1'b0;
      hit       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_wr    <= cpu_wr;
            missed_q  <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            cpu_ready      <= 1'b1;
            hit            <= !missed_q;
            cpu_rdata      <= req_wr ? req_wdata : rd_word;
            lru_q[req_idx] <= ~hit_way;
            if (req_wr) dirty_q[req_idx][hit_way] <= 1'b1;
          end else begin
            missed_q <= 1'b1;
            victim_q <= victim_way;
          end
        end
        S_FETCH: begin
          if (mem_cmplt) fill_line <= mem_rdata;
        end
        S_FILL: begin
          valid_q[req_idx][victim_q] <= 1'b1;
          dirty_q[req_idx][victim_q] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line and tag storage carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_LOOKUP && lookup_hit && req_wr) begin
        data_arr[hit_way][req_idx][int'(req_off)*DATA_W +: DATA_W] <= req_wdata;
      end else if (state == S_FILL) begin
        data_arr[victim_q][req_idx] <= fill_line;
        tag_arr[victim_q][req_idx]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_cache_2way_wb.sv
module tb_cache_2way_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready, hit;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rd, mem_wr, mem_cmplt;

  cache_2way_wb dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .hit       (hit),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_cmplt (mem_cmplt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rdata;
    logic       hit;
  } cpu_exp_t;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t    cpu_q[$];
  mem_exp_t    mem_q[$];
  logic [31:0] fill_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int mem_delay = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_fetch(input logic [23:0] a, input logic [31:0] line);
    mem_q.push_back(mem_exp_t'{wr: 1'b0, addr: a, wdata: 32'h0});
    fill_q.push_back(line);
  endtask

  task automatic exp_wb(input logic [23:0] a, input logic [31:0] line);
    mem_q.push_back(mem_exp_t'{wr: 1'b1, addr: a, wdata: line});
  endtask

  // Issue one request (called right after a negedge) and wait for completion.
  task automatic req(input logic rd, input logic wr, input logic [23:0] a,
                     input logic [7:0] d, input logic [7:0] er, input logic eh);
    int n;
    n = 0;
    cpu_q.push_back(cpu_exp_t'{rdata: er, hit: eh});
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_rd    = rd;
    cpu_wr    = wr;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready && n < 400);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    if (!cpu_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: addr %06h no cpu_ready after %0d cycles", a, n);
      void'(cpu_q.pop_back());
    end else if (eh) begin
      check("hit_latency", 64'(n), 64'd2);
    end
    @(negedge clk);
  endtask

  // CPU-side monitor
  cpu_exp_t mon_e;
  always @(negedge clk) begin
    if (cpu_ready) begin
      if (cpu_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cpu_ready: rdata %02h hit %0b with nothing pending", cpu_rdata, hit);
      end else begin
        mon_e = cpu_q.pop_front();
        check("cpu_rdata", 64'(cpu_rdata), 64'(mon_e.rdata));
        check("hit", 64'(hit), 64'(mon_e.hit));
      end
    end
  end

  // RAM model: checks each new strobe against the expected queue, then
  // completes it after mem_delay cycles.
  bit       busy;
  int       cnt;
  mem_exp_t me;
  initial begin
    mem_cmplt = 1'b0;
    mem_rdata = '0;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      mem_cmplt = 1'b0;
      if (reset) begin
        busy = 1'b0;
        cnt  = 0;
      end else if (mem_rd || mem_wr) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          check("mem_strobe_exclusive", 64'(mem_rd & mem_wr), 64'd0);
          if (mem_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_mem_access: wr %0b addr %06h", mem_wr, mem_addr);
          end else begin
            me = mem_q.pop_front();
            check("mem_wr", 64'(mem_wr), 64'(me.wr));
            check("mem_addr", 64'(mem_addr), 64'(me.addr));
            if (me.wr) check("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
          end
        end else begin
          cnt++;
        end
        if (cnt >= mem_delay) begin
          mem_cmplt = 1'b1;
          busy = 1'b0;
          if (mem_rd) begin
            if (fill_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL no_fill_data: fetch at %06h not expected", mem_addr);
              mem_rdata = '0;
            end else begin
              mem_rdata = fill_q.pop_front();
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [23:0] a0;
  int          w;

  initial begin
    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    check("rst_hit",       64'(hit),       64'd0);
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_mem_rd",    64'(mem_rd),    64'd0);
    check("rst_mem_wr",    64'(mem_wr),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);

    // 1: cold read miss
    exp_fetch(24'h000000, 32'hA1B2C3D4);
    req(1, 0, 24'h000003, 8'h00, 8'hA1, 1'b0);
    // 2: write hit, read back
    req(0, 1, 24'h000003, 8'h56, 8'h56, 1'b1);
    req(1, 0, 24'h000003, 8'h00, 8'h56, 1'b1);
    // 3: second way of set 0
    exp_fetch(24'h010000, 32'h66666666);
    req(1, 0, 24'h010000, 8'h00, 8'h66, 1'b0);
    req(1, 0, 24'h000003, 8'h00, 8'h56, 1'b1);
    // 4: clean eviction, then dirty eviction
    exp_fetch(24'h020000, 32'h11223344);
    req(1, 0, 24'h020000, 8'h00, 8'h44, 1'b0);
    exp_wb(24'h000000, 32'h56B2C3D4);
    exp_fetch(24'h030000, 32'h9988775A);
    req(1, 0, 24'h030000, 8'h00, 8'h5A, 1'b0);
    // 5: write-allocate in set 1, later written back
    exp_fetch(24'h020004, 32'h00BCBCBC);
    req(0, 1, 24'h020007, 8'h55, 8'h55, 1'b0);
    req(1, 0, 24'h020007, 8'h00, 8'h55, 1'b1);
    exp_fetch(24'h000004, 32'h0F0E0D0C);
    req(1, 0, 24'h000004, 8'h00, 8'h0C, 1'b0);
    exp_wb(24'h020004, 32'h55BCBCBC);
    exp_fetch(24'h010004, 32'h77777777);
    req(1, 0, 24'h010004, 8'h00, 8'h77, 1'b0);
    // read and write together: write wins
    req(1, 1, 24'h010004, 8'h3C, 8'h3C, 1'b1);
    req(1, 0, 24'h010004, 8'h00, 8'h3C, 1'b1);

    // 6: stalled fetch, then reset in the middle of it
    mem_delay = 1000000;
    mem_q.push_back(mem_exp_t'{wr: 1'b0, addr: 24'h040000, wdata: 32'h0});
    cpu_addr = 24'h040000;
    cpu_rd   = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_rd && w < 50);
    cpu_rd = 1'b0;
    check("stall_mem_rd_seen", 64'(mem_rd), 64'd1);
    a0 = mem_addr;
    check("stall_mem_addr", 64'(a0), 64'h040000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_mem_rd",    64'(mem_rd),    64'd1);
      check("stall_addr_hold", 64'(mem_addr),  64'(a0));
      check("stall_cpu_ready", 64'(cpu_ready), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_mem_rd",    64'(mem_rd),    64'd0);
    check("midrst_mem_wr",    64'(mem_wr),    64'd0);
    check("midrst_cpu_ready", 64'(cpu_ready), 64'd0);
    check("midrst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    reset = 1'b0;
    mem_delay = 2;
    @(negedge clk);
    exp_fetch(24'h000000, 32'hDEADBEEF);
    req(1, 0, 24'h000003, 8'h00, 8'hDE, 1'b0);

    repeat (4) @(negedge clk);
    check("cpu_q_empty",  64'(cpu_q.size()),  64'd0);
    check("mem_q_empty",  64'(mem_q.size()),  64'd0);
    check("fill_q_empty", 64'(fill_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
